// File: rtl/hhk_sub_pkg.sv
// Shared definitions for the loop-based subtractor hhk_sub.
//   hhk_sub_state_t : controller state (IDLE, RUN, DONE), 2-bit encoding
//   HHK_W           : default operand/result width
package hhk_pkg;

    localparam int HHK_W = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } hhk_sub_state_t;

endpackage

// File: rtl/hhk_sub.sv
// hhk_sub: loop-based subtractor. Latches a/b on start, then steps res and
// cnt down together once per cycle until cnt is zero, leaving res == a - b.
// res - cnt == a - b (mod 2^W) holds throughout an operation.
//
// Ports:
//   clk    in     : clock, rising edge
//   rst    in     : synchronous active-high reset
//   start  in     : operation request, sampled only in IDLE
//   a_in   in  W  : minuend, sampled with start
//   b_in   in  W  : subtrahend, sampled with start
//   a      out W  : latched minuend
//   b      out W  : latched subtrahend
//   res    out W  : running result, final when done is high
//   cnt    out W  : remaining steps
//   busy   out    : high in RUN and DONE
//   done   out    : one-cycle pulse, res final
//   uflow  out    : b > a for the current/last operation
//
// Build option: define HHK_SUB_SAT_EN to saturate res at 0 instead of
// wrapping. uflow and latency are the same in both builds.
//
// state | meaning
// IDLE  | waiting for start, data registers hold last result
// RUN   | stepping res/cnt down until cnt is zero
// DONE  | done pulse cycle, returns to IDLE
module hhk_sub
    import hhk_pkg::*;
#(
    parameter int W = HHK_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic [W-1:0] cnt,
    output logic         busy,
    output logic         done,
    output logic         uflow
);

    localparam logic [W-1:0] ONE = W'(1);

    hhk_sub_state_t state, state_nxt;

    logic [W-1:0] a_q, a_nxt;
    logic [W-1:0] b_q, b_nxt;
    logic [W-1:0] res_q, res_nxt;
    logic [W-1:0] cnt_q, cnt_nxt;
    logic         busy_q, busy_nxt;
    logic         done_q, done_nxt;
    logic         uflow_q, uflow_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            uflow_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            res_q   <= res_nxt;
            cnt_q   <= cnt_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            uflow_q <= uflow_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        res_nxt   = res_q;
        cnt_nxt   = cnt_q;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        uflow_nxt = uflow_q;

        case (state)
            IDLE: begin
                if (start) begin
                    a_nxt     = a_in;
                    b_nxt     = b_in;
                    res_nxt   = a_in;
                    cnt_nxt   = b_in;
                    uflow_nxt = (b_in > a_in);
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    // cnt only decrements while nonzero, so it never wraps
                    cnt_nxt = cnt_q - ONE;
`ifdef HHK_SUB_SAT_EN
                    if (res_q != '0) begin
                        res_nxt = res_q - ONE;
                    end
`else
                    res_nxt = res_q - ONE;
`endif
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign a     = a_q;
    assign b     = b_q;
    assign res   = res_q;
    assign cnt   = cnt_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign uflow = uflow_q;

endmodule
